// File: rtl/alu_sram_ctrl.sv
// alu_sram_ctrl: round-robin sequencer sharing one ALU and one 1RW SRAM between a compute and a read requester
module alu_sram_ctrl #(
  parameter int width_p = 8,
  parameter int addr_width_p = 9,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [width_p-1:0]       cmd_a_i,
  input  logic [width_p-1:0]       cmd_b_i,
  input  logic [addr_width_p-1:0]  cmd_addr_i,
  input  logic                     rd_v_i,
  output logic                     rd_ready_o,
  input  logic [addr_width_p-1:0]  rd_addr_i,
  output logic                     rd_data_v_o,
  output logic [width_p-1:0]       rd_data_o,
  input  logic                     rd_data_yumi_i,
  output logic [1:0]               alu_sel_o,
  output logic [width_p-1:0]       alu_a_o,
  output logic [width_p-1:0]       alu_b_o,
  input  logic [width_p-1:0]       alu_res_i,
  output logic                     sram_ce_o,
  output logic                     sram_we_o,
  output logic [addr_width_p-1:0]  sram_addr_o,
  output logic [width_p-1:0]       sram_wd_o,
  output logic [width_p-1:0]       sram_w_mask_o,
  input  logic [width_p-1:0]       sram_rd_i,
  output logic                     busy_o,
  output logic [count_width_p-1:0] wr_count_o
);
  typedef enum logic [2:0] {IDLE, EXEC, WRITE, READ, LATCH, RESP} state_e;
  localparam logic GRANT_CMD = 1'b0;
  localparam logic GRANT_RD = 1'b1;
  state_e state_r, state_n;
  logic last_grant_r;
  logic [1:0] op_r;
  logic [width_p-1:0] a_r, b_r, res_r, rd_data_r;
  logic [addr_width_p-1:0] addr_r, raddr_r;
  logic [count_width_p-1:0] wr_count_r;
  logic idle, cmd_fire, rd_fire, wr, rd;
  // readies are gated by reset so nothing is offered while reset is held
  assign idle = reset_n_i & (state_r == IDLE);
  assign cmd_ready_o = idle & (~rd_v_i | (last_grant_r == GRANT_RD));
  assign rd_ready_o = idle & (~cmd_v_i | (last_grant_r == GRANT_CMD));
  assign cmd_fire = cmd_v_i & cmd_ready_o;
  assign rd_fire = rd_v_i & rd_ready_o;
  assign wr = state_r == WRITE;
  assign rd = state_r == READ;
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    state_n = cmd_fire ? EXEC : rd_fire ? READ : IDLE;
      EXEC:    state_n = WRITE;
      WRITE:   state_n = IDLE;
      READ:    state_n = LATCH;
      LATCH:   state_n = RESP;
      RESP:    state_n = rd_data_yumi_i ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      last_grant_r <= GRANT_RD;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      addr_r <= '0;
      raddr_r <= '0;
      res_r <= '0;
      rd_data_r <= '0;
      wr_count_r <= '0;
    end else begin
      state_r <= state_n;
      if (cmd_fire) begin
        last_grant_r <= GRANT_CMD;
        op_r <= cmd_op_i;
        a_r <= cmd_a_i;
        b_r <= cmd_b_i;
        addr_r <= cmd_addr_i;
      end
      if (rd_fire) begin
        last_grant_r <= GRANT_RD;
        raddr_r <= rd_addr_i;
      end
      if (state_r == EXEC) res_r <= alu_res_i;
      if (state_r == LATCH) rd_data_r <= sram_rd_i;
      if (wr) wr_count_r <= wr_count_r + count_width_p'(1);
    end
  end
  assign alu_sel_o = op_r;
  assign alu_a_o = a_r;
  assign alu_b_o = b_r;
  assign sram_ce_o = wr | rd;
  assign sram_we_o = wr;
  assign sram_addr_o = wr ? addr_r : rd ? raddr_r : '0;
  assign sram_wd_o = wr ? res_r : '0;
  assign sram_w_mask_o = {width_p{wr}};
  assign rd_data_v_o = state_r == RESP;
  assign rd_data_o = rd_data_r;
  assign busy_o = state_r != IDLE;
  assign wr_count_o = wr_count_r;
endmodule

// File: tb/tb_alu_sram_ctrl.sv
// tb_alu_sram_ctrl: table vectors plus write/read scoreboards against a stub adder ALU and a 512x8 SRAM model
module tb_alu_sram_ctrl;
  logic clk, reset_n;
  logic cmd_v, cmd_ready, rd_v, rd_ready, rd_data_v, yumi;
  logic [1:0] cmd_op, alu_sel;
  logic [7:0] cmd_a, cmd_b, rd_data, alu_a, alu_b, alu_res, sram_wd, sram_mask, sram_rd;
  logic [8:0] cmd_addr, rd_addr, sram_addr;
  logic sram_ce, sram_we, busy;
  logic [15:0] wr_count;
  logic [7:0] mem [512] = '{default: 8'hA5};
  typedef struct {logic [1:0] op; logic [7:0] a; logic [7:0] b; logic [8:0] ad; logic [7:0] exp;} vec_t;
  typedef struct {logic [8:0] ad; logic [7:0] d; logic [1:0] op;} wr_t;
  vec_t tv [6];
  wr_t wsb [$];
  logic [7:0] rsb [$];
  int grants [$];
  int passed = 0, total = 0, cyc = 0, t_acc = 0;

  alu_sram_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .cmd_addr_i(cmd_addr), .rd_v_i(rd_v), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rd_data_v_o(rd_data_v), .rd_data_o(rd_data), .rd_data_yumi_i(yumi),
    .alu_sel_o(alu_sel), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_res_i(alu_res),
    .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wd_o(sram_wd),
    .sram_w_mask_o(sram_mask), .sram_rd_i(sram_rd), .busy_o(busy), .wr_count_o(wr_count)
  );

  assign alu_res = alu_a + alu_b;
  always @(posedge clk) begin
    if (sram_ce && sram_we) mem[sram_addr] <= (sram_wd & sram_mask) | (mem[sram_addr] & ~sram_mask);
    else if (sram_ce) sram_rd <= mem[sram_addr];
  end

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (sram_ce && sram_we) begin
      check("wr_expected", wsb.size() > 0, 1);
      if (wsb.size() > 0) begin
        e = wsb.pop_front();
        check("wr_addr", sram_addr, e.ad);
        check("wr_data", sram_wd, e.d);
        check("wr_mask", sram_mask, 8'hFF);
        check("wr_sel", alu_sel, e.op);
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] ad, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    cmd_v = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_addr = ad;
    wsb.push_back('{ad: ad, d: exp, op: op});
    #1;
    while (!cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("cmd_accept", cmd_ready, 1);
    t_acc = cyc;
    @(posedge clk);
    #1 cmd_v = 0;
  endtask

  task automatic rd_issue(input logic [8:0] ad, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    rd_v = 1; rd_addr = ad;
    rsb.push_back(exp);
    #1;
    while (!rd_ready && n < 50) begin @(negedge clk); #1; n++; end
    check("rd_accept", rd_ready, 1);
    t_acc = cyc;
    @(posedge clk);
    #1 rd_v = 0;
  endtask

  task automatic rd_wait();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_data_v && n < 50);
    check("rd_valid", rd_data_v, 1);
    check("rd_latency", cyc - t_acc, 3);
  endtask

  task automatic rd_collect(input int hold);
    logic [7:0] exp;
    check("rd_expected", rsb.size() > 0, 1);
    exp = rsb.size() > 0 ? rsb.pop_front() : 8'h00;
    check("rd_data", rd_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rd_hold_v", rd_data_v, 1);
      check("rd_hold_data", rd_data, exp);
    end
    yumi = 1;
    @(posedge clk);
    #1 yumi = 0;
    check("rd_drop", rd_data_v, 0);
  endtask

  task automatic do_rd(input logic [8:0] ad, input logic [7:0] exp, input int hold);
    rd_issue(ad, exp);
    rd_wait();
    rd_collect(hold);
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    wsb.delete();
    rsb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] ad;
    tv[0] = '{2'b00, 8'h10, 8'h20, 9'd0,   8'h30};
    tv[1] = '{2'b01, 8'hFF, 8'h01, 9'd511, 8'h00};
    tv[2] = '{2'b10, 8'h80, 8'h80, 9'd256, 8'h00};
    tv[3] = '{2'b11, 8'h7F, 8'h01, 9'd255, 8'h80};
    tv[4] = '{2'b01, 8'hAA, 8'h55, 9'd1,   8'hFF};
    tv[5] = '{2'b10, 8'h00, 8'h00, 9'd300, 8'h00};
    reset_n = 0; cmd_v = 1; rd_v = 1; yumi = 0;
    cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_addr = 0; rd_addr = 0;
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ce", sram_ce, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_v", rd_data_v, 0);
    cmd_v = 0; rd_v = 0;
    @(negedge clk);
    reset_n = 1;
    do_cmd(2'b00, 8'd1, 8'd3, 9'd5, 8'd4);
    @(negedge clk);
    check("exec_ce", sram_ce, 0);
    check("exec_busy", busy, 1);
    check("exec_a", alu_a, 8'd1);
    check("exec_b", alu_b, 8'd3);
    @(negedge clk);
    check("write_ce_we", {sram_ce, sram_we}, 2'b11);
    check("write_latency", cyc - t_acc, 2);
    @(negedge clk);
    check("wr_count_1", wr_count, 16'd1);
    check("idle_after_write", busy, 0);
    do_rd(9'd5, 8'd4, 4);
    for (int i = 0; i < 6; i++) do_cmd(tv[i].op, tv[i].a, tv[i].b, tv[i].ad, tv[i].exp);
    for (int i = 0; i < 6; i++) do_rd(tv[i].ad, tv[i].exp, i % 2);
    do_cmd(2'b00, 8'd9, 8'd9, 9'd200, 8'd18);
    #2 reset_n = 0;
    #1;
    check("abort_ce", sram_ce, 0);
    check("abort_we", sram_we, 0);
    check("abort_busy", busy, 0);
    check("abort_alu_a", alu_a, 0);
    check("abort_alu_b", alu_b, 0);
    check("abort_addr", sram_addr, 0);
    check("abort_wr_count", wr_count, 0);
    pulse_reset();
    do_rd(9'd200, 8'hA5, 0);
    rd_issue(9'd5, 8'd4);
    rd_wait();
    cmd_op = 2'b10; cmd_a = 8'd7; cmd_b = 8'd8; cmd_addr = 9'd100; rd_addr = 9'd100;
    cmd_v = 1; rd_v = 1;
    #2 reset_n = 0;
    #1;
    check("resp_rst_v", rd_data_v, 0);
    check("resp_rst_data", rd_data, 0);
    check("resp_rst_cmd_ready", cmd_ready, 0);
    check("resp_rst_rd_ready", rd_ready, 0);
    rsb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 40; i++) begin
      #1;
      check("ready_exclusive", cmd_ready & rd_ready, 0);
      if (cmd_ready) begin
        grants.push_back(0);
        wsb.push_back('{ad: 9'd100, d: 8'd15, op: 2'b10});
      end
      if (rd_ready) grants.push_back(1);
      yumi = rd_data_v;
      if (rd_data_v) check("cont_rd_data", rd_data, 8'd15);
      @(negedge clk);
    end
    cmd_v = 0; rd_v = 0; yumi = 0;
    check("grant_count", grants.size() >= 4, 1);
    foreach (grants[i]) check("grant_order", grants[i], i % 2);
    pulse_reset();
    for (int i = 0; i < 512; i++) begin
      ad = 9'(i);
      do_cmd(2'b00, ad[7:0], 8'd0, ad, ad[7:0]);
    end
    for (int i = 0; i < 512; i++) begin
      ad = 9'(i);
      do_rd(ad, ad[7:0], 0);
    end
    check("wr_count_512", wr_count, 16'd512);
    check("wsb_drained", wsb.size(), 0);
    check("rsb_drained", rsb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
